rx_block_lock: RTL and testbench
================================

# rx_block_lock

Receive block-lock controller for the 10GBASE-R PCS. It sits between the transceiver's Rx gearbox outputs (`data_valid`, `header_valid`, `header`) and the `o_xver_rx_gearbox_slip` input of the GTY. It runs an IEEE 802.3 Clause 49 style lock state machine and reports `o_block_lock` to the descrambler and decoder. It also sequences gearbox slips, with a mandatory settle interval after each slip.

## Interface
Parameters:
- `SH_CNT_MAX`, 64: number of evaluated sync headers in one test window.
- `SH_INVALID_MAX`, 16: number of invalid headers in one window that forces loss of lock.
- `SLIP_WAIT`, 64: number of clock cycles to ignore headers after each slip pulse (gearbox settle time); must be ≥1.

Ports:
- `i_xver_rx_clk`  in  1  Rx user clock (usrclk2). The block has a single clock.
- `i_rx_reset`  in  1  Reset, synchronous, active-high.
- `i_xver_rx_header`  in  2  Sync header of the current 66b block.
- `i_xver_rx_header_valid`  in  1  `i_xver_rx_header` is meaningful this cycle (first word of a block).
- `i_xver_rx_data_valid`  in  1  Gearbox data valid; low during gearbox pause cycles.
- `o_xver_rx_gearbox_slip`  out  1  One-cycle slip request to the GTY gearbox.
- `o_block_lock`  out  1  Block lock achieved.
- `o_header_err`  out  1  One-cycle pulse for each evaluated invalid header.
- `o_slip_count`  out  16  Saturating count of slips issued since reset.

## Operation
- **Evaluated header:** a header is evaluated only in a cycle where `i_xver_rx_header_valid && i_xver_rx_data_valid`. It is valid when it is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- **Counters:**
  - `sh_cnt`, width $clog2(SH_CNT_MAX+1).
  - `sh_invalid_cnt`, width $clog2(SH_INVALID_MAX+1).
  - `wait_cnt`, width $clog2(SLIP_WAIT+1).
- **States:** RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
- **RESET_CNT:** clear `sh_cnt` and `sh_invalid_cnt`, then go to TEST_SH on the next cycle. Headers arriving in RESET_CNT are not evaluated.
- **TEST_SH, valid header:** `sh_cnt`++.
  - If the new `sh_cnt` equals SH_CNT_MAX and `sh_invalid_cnt` == 0, set `o_block_lock` = 1 and go to RESET_CNT.
  - If the new `sh_cnt` equals SH_CNT_MAX and `sh_invalid_cnt` > 0, go to RESET_CNT with lock unchanged.
- **TEST_SH, invalid header:** `sh_cnt`++ and `sh_invalid_cnt`++, and pulse `o_header_err`.
  - If `o_block_lock` == 0, or the new `sh_invalid_cnt` equals SH_INVALID_MAX, clear `o_block_lock` and go to SLIP.
  - Otherwise, if the new `sh_cnt` equals SH_CNT_MAX, go to RESET_CNT.
- **SLIP:** hold for one cycle with `o_xver_rx_gearbox_slip` = 1.
  - Increment `o_slip_count`; it saturates at 16'hFFFF.
  - Load `wait_cnt` = SLIP_WAIT, then go to SLIP_WAIT.
- **SLIP_WAIT:** decrement `wait_cnt` each cycle and ignore all headers. Go to RESET_CNT on the cycle `wait_cnt` reaches 0.
- **Simultaneous events:**
  - An evaluated header that arrives in SLIP, SLIP_WAIT or RESET_CNT is dropped and does not pulse `o_header_err`.
  - A header that completes the window and also hits SH_INVALID_MAX takes the SLIP branch.
- **Reset:** `i_rx_reset` overrides everything, including mid-slip and mid-wait. A slip pulse in flight is cut off in the reset cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `o_xver_rx_gearbox_slip` = 0
  - `o_block_lock` = 0
  - `o_header_err` = 0
  - `o_slip_count` = 0
  - state = RESET_CNT
- Lock latency: `o_block_lock` rises one cycle after the clock edge that samples the SH_CNT_MAX-th consecutive valid header.
- Slip latency: the slip pulse is high exactly one cycle, in the cycle after the invalid header is sampled. `o_block_lock` falls in that same cycle.
- `o_header_err` is high in the cycle after the invalid header is sampled.
- Minimum spacing between slip pulses is SLIP_WAIT + 3 cycles: 1 slip cycle, SLIP_WAIT wait cycles, 1 RESET_CNT cycle, then at least 1 cycle to sample a header.
- Cycles with `i_xver_rx_data_valid` = 0 do not advance any header counter. `wait_cnt` still decrements.

## Test plan
- **Reset and acquire:** release reset, then drive 64 evaluated headers of 2'b01 at one header every 2 cycles. Expect `o_block_lock` = 1 one cycle after the 64th header is sampled, and no slip pulses.
- **Unlocked invalid header:** from reset, drive one header of 2'b11. Expect the slip pulse for exactly 1 cycle on the next cycle, `o_slip_count` = 1, and no further slip for at least 67 cycles even if invalid headers continue.
- **Lock tolerance:** while locked, drive 15 invalid headers within one 64-header window. Expect `o_block_lock` to stay at 1, 15 `o_header_err` pulses, and no slip.
- **Lock loss:** while locked, drive 16 invalid headers within one window. Expect `o_block_lock` to fall and the slip pulse to fire one cycle after the 16th invalid header.
- **Gearbox pause gating:** hold `i_xver_rx_data_valid` = 0 while `header_valid` = 1 and the header is 2'b00. Expect no `o_header_err` pulse and no change to any counter.
- **Reset mid-wait:** assert `i_rx_reset` for 1 cycle 10 cycles into SLIP_WAIT. Expect all outputs to return to 0 (including `o_slip_count`) and re-acquisition to succeed from 64 fresh valid headers.

Source files
------------

// File: rtl/rx_block_lock.sv
// 10GBASE-R receive block-lock FSM: validates 66b sync headers, declares lock after a clean
// window, and issues one-cycle gearbox slips followed by a fixed settle interval.
module rx_block_lock #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 64
) (
  input  logic        i_xver_rx_clk,
  input  logic        i_rx_reset,
  input  logic [1:0]  i_xver_rx_header,
  input  logic        i_xver_rx_header_valid,
  input  logic        i_xver_rx_data_valid,
  output logic        o_xver_rx_gearbox_slip,
  output logic        o_block_lock,
  output logic        o_header_err,
  output logic [15:0] o_slip_count
);

  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int IVW = $clog2(SH_INVALID_MAX + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  localparam logic [1:0] ST_RESET_CNT = 2'd0;
  localparam logic [1:0] ST_TEST_SH   = 2'd1;
  localparam logic [1:0] ST_SLIP      = 2'd2;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd3;

  logic [1:0]     r_state;
  logic [SHW-1:0] r_sh_cnt;
  logic [IVW-1:0] r_inv_cnt;
  logic [WTW-1:0] r_wait_cnt;
  logic           r_slip;
  logic           r_lock;
  logic           r_err;
  logic [15:0]    r_slip_cnt;

  logic           w_eval;
  logic           w_hdr_ok;
  logic [SHW-1:0] w_sh_cnt_nxt;
  logic [IVW-1:0] w_inv_cnt_nxt;
  logic           w_win_done;
  logic           w_inv_max;

  // Headers only count in TEST_SH; gearbox pause cycles never advance anything.
  assign w_eval        = i_xver_rx_header_valid && i_xver_rx_data_valid && (r_state == ST_TEST_SH);
  assign w_hdr_ok      = i_xver_rx_header[1] ^ i_xver_rx_header[0];
  assign w_sh_cnt_nxt  = r_sh_cnt + SHW'(1);
  assign w_inv_cnt_nxt = r_inv_cnt + IVW'(1);
  assign w_win_done    = (w_sh_cnt_nxt == SHW'(SH_CNT_MAX));
  assign w_inv_max     = (w_inv_cnt_nxt == IVW'(SH_INVALID_MAX));

  always_ff @(posedge i_xver_rx_clk) begin
    if (i_rx_reset) begin
      r_state    <= ST_RESET_CNT;
      r_sh_cnt   <= '0;
      r_inv_cnt  <= '0;
      r_wait_cnt <= '0;
      r_slip     <= 1'b0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
      r_slip_cnt <= '0;
    end else begin
      r_slip <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_RESET_CNT: begin
          r_sh_cnt  <= '0;
          r_inv_cnt <= '0;
          r_state   <= ST_TEST_SH;
        end
        ST_TEST_SH: begin
          if (w_eval) begin
            r_sh_cnt <= w_sh_cnt_nxt;
            if (w_hdr_ok) begin
              if (w_win_done) begin
                if (r_inv_cnt == '0) r_lock <= 1'b1;
                r_state <= ST_RESET_CNT;
              end
            end else begin
              r_err     <= 1'b1;
              r_inv_cnt <= w_inv_cnt_nxt;
              // Slip wins over window completion when both happen on the same header.
              if (!r_lock || w_inv_max) begin
                r_lock  <= 1'b0;
                r_slip  <= 1'b1;
                r_state <= ST_SLIP;
              end else if (w_win_done) begin
                r_state <= ST_RESET_CNT;
              end
            end
          end
        end
        ST_SLIP: begin
          if (r_slip_cnt != 16'hFFFF) r_slip_cnt <= r_slip_cnt + 16'd1;
          r_wait_cnt <= WTW'(SLIP_WAIT);
          r_state    <= ST_SLIP_WAIT;
        end
        default: begin
          r_wait_cnt <= r_wait_cnt - WTW'(1);
          if (r_wait_cnt == WTW'(1)) r_state <= ST_RESET_CNT;
        end
      endcase
    end
  end

  assign o_xver_rx_gearbox_slip = r_slip;
  assign o_block_lock           = r_lock;
  assign o_header_err           = r_err;
  assign o_slip_count           = r_slip_cnt;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: acquisition, pause gating, lock tolerance/loss,
// slip spacing and reset during the settle interval.
module tb_rx_block_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  hdr = 2'b00;
  logic        hv  = 1'b0;
  logic        dv  = 1'b0;
  logic        slip;
  logic        lock;
  logic        err;
  logic [15:0] slip_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int slip_seen = 0;
  int lock_drops = 0;
  bit lock_watch = 1'b0;

  rx_block_lock #(
    .SH_CNT_MAX(64),
    .SH_INVALID_MAX(16),
    .SLIP_WAIT(64)
  ) dut (
    .i_xver_rx_clk(clk),
    .i_rx_reset(rst),
    .i_xver_rx_header(hdr),
    .i_xver_rx_header_valid(hv),
    .i_xver_rx_data_valid(dv),
    .o_xver_rx_gearbox_slip(slip),
    .o_block_lock(lock),
    .o_header_err(err),
    .o_slip_count(slip_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) err_seen++;
    if (slip) slip_seen++;
    if (lock_watch && !lock) lock_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one evaluated header; returns just after the sampling edge.
  task automatic sample_hdr(input logic [1:0] h);
    hdr = h;
    hv  = 1'b1;
    dv  = 1'b1;
    tick();
  endtask

  // Gap cycle: optionally a header_valid with data_valid low, which must be ignored.
  task automatic idle(input logic junk_hv, input logic [1:0] junk_h);
    hv  = junk_hv;
    hdr = junk_h;
    dv  = 1'b0;
    tick();
  endtask

  task automatic send_hdr(input logic [1:0] h, input logic junk_hv, input logic [1:0] junk_h);
    sample_hdr(h);
    idle(junk_hv, junk_h);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    hv  = 1'b0;
    dv  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic acquire(input string tag);
    for (int i = 0; i < 63; i++) send_hdr(2'b01, 1'b1, 2'b01);
    check({tag, "_lock_before_64"}, {31'd0, lock}, 32'd0);
    sample_hdr(2'b01);
    check({tag, "_lock_at_64"}, {31'd0, lock}, 32'd1);
    idle(1'b1, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int s0;
    int gap;
    bit found;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_slip", {31'd0, slip}, 32'd0);
    check("rst_lock", {31'd0, lock}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_slip_cnt", {16'd0, slip_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Invalid header presented only during gearbox pause cycles.
    e0 = err_seen;
    s0 = slip_seen;
    hv = 1'b1; dv = 1'b0; hdr = 2'b00;
    repeat (10) tick();
    hv = 1'b0;
    check("pause_err", err_seen - e0, 32'd0);
    check("pause_slip", slip_seen - s0, 32'd0);
    check("pause_slip_cnt", {16'd0, slip_cnt}, 32'd0);

    s0 = slip_seen;
    acquire("acq");
    check("acq_no_slip", slip_seen - s0, 32'd0);

    // 15 invalid headers within one window keeps lock.
    e0 = err_seen;
    s0 = slip_seen;
    lock_watch = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < 15) send_hdr((i % 2 == 1) ? 2'b11 : 2'b00, 1'b1, 2'b00);
      else        send_hdr(2'b10, 1'b1, 2'b00);
    end
    lock_watch = 1'b0;
    check("tol_lock", {31'd0, lock}, 32'd1);
    check("tol_errs", err_seen - e0, 32'd15);
    check("tol_slips", slip_seen - s0, 32'd0);
    check("tol_lock_drops", lock_drops, 32'd0);

    // 16th invalid header in a window drops lock and slips.
    e0 = err_seen;
    s0 = slip_seen;
    for (int i = 0; i < 10; i++) send_hdr(2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 15; i++) send_hdr(2'b11, 1'b0, 2'b00);
    check("loss_pre_slip", slip_seen - s0, 32'd0);
    check("loss_pre_lock", {31'd0, lock}, 32'd1);
    sample_hdr(2'b00);
    check("loss_slip", {31'd0, slip}, 32'd1);
    check("loss_lock", {31'd0, lock}, 32'd0);
    check("loss_err", {31'd0, err}, 32'd1);
    idle(1'b0, 2'b00);
    check("loss_slip_width", {31'd0, slip}, 32'd0);
    check("loss_errs", err_seen - e0, 32'd16);

    // Unlocked: first invalid header slips, then slips are spaced SLIP_WAIT+3.
    reset_dut();
    sample_hdr(2'b11);
    check("unl_slip", {31'd0, slip}, 32'd1);
    check("unl_err", {31'd0, err}, 32'd1);
    tick();
    check("unl_slip_1cyc", {31'd0, slip}, 32'd0);
    check("unl_slip_cnt", {16'd0, slip_cnt}, 32'd1);
    e0 = err_seen;
    gap = 0;
    found = 1'b0;
    for (int k = 2; k <= 100 && !found; k++) begin
      tick();
      if (slip) begin
        found = 1'b1;
        gap = k;
      end
    end
    check("unl_gap", gap, 32'd67);
    check("unl_wait_no_err", err_seen - e0, 32'd0);
    check("unl_err_second", {31'd0, err}, 32'd1);

    // Reset ten cycles into the settle interval.
    repeat (11) tick();
    check("mw_slip_cnt_pre", {16'd0, slip_cnt}, 32'd2);
    rst = 1'b1;
    tick();
    check("mw_slip", {31'd0, slip}, 32'd0);
    check("mw_lock", {31'd0, lock}, 32'd0);
    check("mw_err", {31'd0, err}, 32'd0);
    check("mw_slip_cnt", {16'd0, slip_cnt}, 32'd0);
    rst = 1'b0;
    hv = 1'b0;
    dv = 1'b0;
    tick();
    s0 = slip_seen;
    acquire("reacq");
    check("reacq_no_slip", slip_seen - s0, 32'd0);
    check("reacq_slip_cnt", {16'd0, slip_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
